// File: rtl/demux_serial_driver_if.sv
// demux_serial_driver_if: word-in handshake plus the serial/select outputs
// that feed the 1:4 dataflow demux. The driver block sits on the slave
// modport; whatever supplies words (and watches the serial side) uses master.
interface demux_serial_driver_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_dest;
  logic             d;
  logic             s0;
  logic             s1;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data, in_dest,
    input  in_ready, d, s0, s1, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_dest,
    output in_ready, d, s0, s1, busy, done
  );
endinterface

// File: rtl/demux_serial_driver.sv
// demux_serial_driver: takes a parallel word and a 2-bit destination over a
// valid/ready handshake, shifts the word out MSB-first on d while s0/s1 stay
// fixed for the whole frame, then idles for GAP_CYCLES with the select held.
// Every output comes straight from a register.
// Optional build macro DEMUX_DRV_PARITY_EN appends one even-parity bit
// (XOR of the data bits) to every frame.
module demux_serial_driver #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  demux_serial_driver_if.slave bus
);

`ifdef DEMUX_DRV_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int             CW       = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0]  BIT_LAST = CW'(FRAME_BITS - 1);
  localparam bit             HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [3:0]     GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             d_q, d_d;
  logic             s0_q, s0_d;
  logic             s1_q, s1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;
  logic             tail_bit;

  // The bit that follows the data bits once the shift register empties:
  // the frame parity when enabled, otherwise nothing is ever shifted out of it.
`ifdef DEMUX_DRV_PARITY_EN
  assign tail_bit = ^bus.in_data;
`else
  assign tail_bit = 1'b0;
`endif

  // State and output registers; reset clears everything, including in_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      gap_cnt_q <= '0;
      d_q       <= 1'b0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      gap_cnt_q <= gap_cnt_d;
      d_q       <= d_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdy_q     <= rdy_d;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so that the registered values line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    gap_cnt_d = gap_cnt_q;
    d_d       = 1'b0;
    s0_d      = s0_q;
    s1_d      = s1_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdy_d     = rdy_q;

    case (state_q)
      S_IDLE: begin
        s0_d   = 1'b0;
        s1_d   = 1'b0;
        busy_d = 1'b0;
        rdy_d  = 1'b1;
        // rdy_q (not rdy_d) gates the accept, so the first cycle after
        // reset only raises in_ready and never takes a word.
        if (bus.in_valid && rdy_q) begin
          state_d = S_SHIFT;
          // MSB goes out in the very next cycle; the rest waits in shreg
          // already shifted by one, with the tail bit filling the LSB.
          d_d     = bus.in_data[WIDTH-1];
          shreg_d = {bus.in_data[WIDTH-2:0], tail_bit};
          cnt_d   = '0;
          s0_d    = bus.in_dest[1];
          s1_d    = bus.in_dest[0];
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
        end
      end

      S_SHIFT: begin
        // cnt_q is the index of the bit currently on d.
        if (cnt_q == BIT_LAST) begin
          done_d = 1'b1;
          if (HAS_GAP) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
            s0_d    = 1'b0;
            s1_d    = 1'b0;
            busy_d  = 1'b0;
            rdy_d   = 1'b1;
          end
        end else begin
          d_d     = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          s0_d    = 1'b0;
          s1_d    = 1'b0;
          busy_d  = 1'b0;
          rdy_d   = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        s0_d    = 1'b0;
        s1_d    = 1'b0;
        busy_d  = 1'b0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  assign bus.in_ready = rdy_q;
  assign bus.d        = d_q;
  assign bus.s0       = s0_q;
  assign bus.s1       = s1_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_demux_serial_driver.sv
// tb_demux_serial_driver: two driver instances (GAP_CYCLES=1 and 0) fed with
// directed words. Every accepted word queues its expected cycle-by-cycle
// outputs; per-instance monitors pop one record per cycle on the falling edge.
module tb_demux_serial_driver;
  localparam int W  = 8;
  localparam int GA = 1;
  localparam int GB = 0;
`ifdef DEMUX_DRV_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  // {d, s0, s1, busy, done, in_ready}
  typedef struct packed {
    logic d;
    logic s0;
    logic s1;
    logic busy;
    logic done;
    logic rdy;
  } out_t;

  localparam out_t IDLE_OUT  = 6'b000001;
  localparam out_t RESET_OUT = 6'b000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_serial_driver_if #(.WIDTH(W)) ifa ();
  demux_serial_driver_if #(.WIDTH(W)) ifb ();

  demux_serial_driver #(.WIDTH(W), .GAP_CYCLES(GA)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa.slave)
  );

  demux_serial_driver #(.WIDTH(W), .GAP_CYCLES(GB)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb.slave)
  );

  out_t exp_q0[$];
  out_t exp_q1[$];
  int   acc_cyc0[$];
  int   acc_cyc1[$];
  int   tests = 0;
  int   fails = 0;
  int   acc0 = 0;
  int   acc1 = 0;
  int   cyc = 0;
  bit   mon_en0 = 1'b0;
  bit   mon_en1 = 1'b0;
  logic par0 = 1'b0;
  logic par1 = 1'b0;
  out_t act0, act1;

  function automatic void push_rec(int u, out_t r);
    if (u == 0) exp_q0.push_back(r);
    else        exp_q1.push_back(r);
  endfunction

  // Expected outputs for every cycle from the accept edge to the IDLE cycle.
  function automatic void push_frame(int u, logic [W-1:0] data, logic [1:0] dest,
                                     int gap, logic par);
    for (int i = 0; i < W; i++)
      push_rec(u, {data[W-1-i], dest[1], dest[0], 1'b1, 1'b0, 1'b0});
    if (PB == 1)
      push_rec(u, {par, dest[1], dest[0], 1'b1, 1'b0, 1'b0});
    for (int j = 0; j < gap; j++)
      push_rec(u, {1'b0, dest[1], dest[0], 1'b1, (j == 0), 1'b0});
    push_rec(u, {1'b0, 1'b0, 1'b0, 1'b0, (gap == 0), 1'b1});
  endfunction

  task automatic check(string name, out_t act, out_t expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got d,s0,s1,busy,done,in_ready=%b want %b (t=%0t)",
               name, act, expv, $time);
    end else begin
      $display("[TB] ok %s: %b", name, act);
    end
  endtask

  task automatic check_int(string name, int act, int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end else begin
      $display("[TB] ok %s: %0d", name, act);
    end
  endtask

  // Accept detector: an edge with valid & ready (pre-edge values) starts a frame.
  always @(posedge clk) begin
    if (rst_n && ifa.in_valid && ifa.in_ready) begin
      push_frame(0, ifa.in_data, ifa.in_dest, GA, par0);
      acc_cyc0.push_back(cyc);
      acc0++;
    end
    if (rst_n && ifb.in_valid && ifb.in_ready) begin
      push_frame(1, ifb.in_data, ifb.in_dest, GB, par1);
      acc_cyc1.push_back(cyc);
      acc1++;
    end
    cyc++;
  end

  // Monitors: one expected record per cycle, idle outputs when nothing queued.
  always @(negedge clk) begin
    if (mon_en0) begin
      act0 = {ifa.d, ifa.s0, ifa.s1, ifa.busy, ifa.done, ifa.in_ready};
      if (exp_q0.size() > 0) check("A frame", act0, exp_q0.pop_front());
      else                   check("A idle", act0, IDLE_OUT);
    end
    if (mon_en1) begin
      act1 = {ifb.d, ifb.s0, ifb.s1, ifb.busy, ifb.done, ifb.in_ready};
      if (exp_q1.size() > 0) check("B frame", act1, exp_q1.pop_front());
      else                   check("B idle", act1, IDLE_OUT);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and keep in_valid high until it is taken (bounded wait).
  task automatic send(int u, logic [W-1:0] data, logic [1:0] dest, logic par);
    int start;
    start = (u == 0) ? acc0 : acc1;
    if (u == 0) begin
      par0 = par; ifa.in_data = data; ifa.in_dest = dest; ifa.in_valid = 1'b1;
    end else begin
      par1 = par; ifb.in_data = data; ifb.in_dest = dest; ifb.in_valid = 1'b1;
    end
    for (int n = 0; n < 200; n++) begin
      tick();
      if (((u == 0) ? acc0 : acc1) != start) begin
        tests++;
        $display("[TB] unit %0d accepted data %h dest %b", u, data, dest);
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL accept unit %0d data %h: not accepted within 200 cycles, expected accept", u, data);
  endtask

  task automatic drop(int u);
    if (u == 0) ifa.in_valid = 1'b0;
    else        ifb.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() > 0 || exp_q1.size() > 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL drain: expected records still pending after 200 cycles, want none");
    end
    tick();
    tick();
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_dest = '0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_dest = '0;

    // Power-up reset
    rst_n = 1'b0;
    tick();
    tick();
    check("A reset state", {ifa.d, ifa.s0, ifa.s1, ifa.busy, ifa.done, ifa.in_ready}, RESET_OUT);
    check("B reset state", {ifb.d, ifb.s0, ifb.s1, ifb.busy, ifb.done, ifb.in_ready}, RESET_OUT);
    rst_n = 1'b1;
    tick();
    check("A ready after reset", {ifa.d, ifa.s0, ifa.s1, ifa.busy, ifa.done, ifa.in_ready}, IDLE_OUT);
    check("B ready after reset", {ifb.d, ifb.s0, ifb.s1, ifb.busy, ifb.done, ifb.in_ready}, IDLE_OUT);
    mon_en0 = 1'b1;
    mon_en1 = 1'b1;

    // Basic frame: A5 to y2 (parity 0)
    send(0, 8'hA5, 2'b10, 1'b0);
    drop(0);
    drain();

    // Stall: FF/01 raised during the SHIFT of 3C/00; taken only at IDLE
    send(0, 8'h3C, 2'b00, 1'b0);
    send(0, 8'hFF, 2'b01, 1'b0);
    drop(0);
    drain();

    // All destinations back-to-back with in_valid held high
    acc_cyc0.delete();
    for (int dst = 0; dst < 4; dst++)
      send(0, 8'h81, 2'(dst), 1'b0);
    drop(0);
    drain();
    for (int i = 1; i < 4; i++)
      check_int("A accept spacing", acc_cyc0[i] - acc_cyc0[i-1], W + GA + PB + 1);

    // No-gap instance: 01 to y3 (parity 1), then 07 to y1 (parity 1)
    acc_cyc1.delete();
    send(1, 8'h01, 2'b11, 1'b1);
    send(1, 8'h07, 2'b01, 1'b1);
    drop(1);
    drain();
    check_int("B accept spacing", acc_cyc1[1] - acc_cyc1[0], W + GB + PB + 1);

    // Reset in the middle of a frame: A5 to y2, abort after three bits
    send(0, 8'hA5, 2'b10, 1'b0);
    drop(0);
    tick();
    tick();
    mon_en0 = 1'b0;
    mon_en1 = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    rst_n = 1'b0;
    tick();
    check("A mid-frame reset", {ifa.d, ifa.s0, ifa.s1, ifa.busy, ifa.done, ifa.in_ready}, RESET_OUT);
    tick();
    tick();
    check("A held in reset", {ifa.d, ifa.s0, ifa.s1, ifa.busy, ifa.done, ifa.in_ready}, RESET_OUT);
    rst_n = 1'b1;
    tick();
    check("A ready after abort", {ifa.d, ifa.s0, ifa.s1, ifa.busy, ifa.done, ifa.in_ready}, IDLE_OUT);
    mon_en0 = 1'b1;
    mon_en1 = 1'b1;
    for (int n = 0; n < 12; n++) tick();

    // A fresh frame after the abort: 07 to y3 (parity 1)
    send(0, 8'h07, 2'b11, 1'b1);
    drop(0);
    drain();

    mon_en0 = 1'b0;
    mon_en1 = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
